// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit path, receive path and
// their buffers.
//   UART_DATA_W  - width of one UART data frame payload
//   txb_state_e  - states of the transmit-buffer drain controller
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        TXB_IDLE  = 2'd0,
        TXB_START = 2'd1,
        TXB_WAIT  = 2'd2
    } txb_state_e;

endpackage

// File: rtl/uart_tx_buffer_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO with a separate occupancy
// counter, so full and empty never need pointer-based disambiguation.
// It is written to be reused for the receive-side buffer as well.
//   clk_i       in   system clock, rising edge
//   rst_ni      in   asynchronous reset, active low
//   push_i      in   enqueue request; ignored (and flagged) while full
//   push_data_i in   WIDTH-bit entry to enqueue
//   pop_i       in   dequeue request; ignored while empty
//   pop_data_o  out  entry at the read pointer (valid while not empty)
//   full_o      out  count == DEPTH, decoded from the count register
//   empty_o     out  count == 0, decoded from the count register
//   count_o     out  registered occupancy, 0..DEPTH
//   overflow_o  out  one-cycle pulse after a push attempted while full
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push_ok;
    logic              pop_ok;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == {CNT_W{1'b0}});
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy and the overflow flag.
    always_comb begin
        // full/empty are the pre-edge values: a same-cycle pop never rescues a push
        push_ok    = push_i & ~full_o;
        pop_ok     = pop_i & ~empty_o;
        overflow_d = push_i & full_o;

        // DEPTH is a power of two, so plain ADDR_W-bit increment wraps correctly
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= {ADDR_W{1'b0}};
            rd_ptr_q   <= {ADDR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO plus drain controller feeding a UART transmitter
// one frame at a time. A byte is popped into the tx_data register, announced
// with a one-cycle tx_start pulse, and held until the transmitter's tx_done.
//   clk_i      in   system clock, rising edge
//   rst_ni     in   asynchronous reset, active low; discards buffered bytes
//   wr_en_i    in   write strobe; wr_data_i pushed if not full
//   wr_data_i  in   byte to enqueue
//   full_o     out  FIFO holds DEPTH bytes
//   empty_o    out  FIFO holds no bytes
//   count_o    out  FIFO occupancy, 0..DEPTH (excludes the byte in tx_data)
//   overflow_o out  one-cycle pulse: a write was dropped because FIFO was full
//   tx_start_o out  one-cycle pulse to the transmitter's start input
//   tx_data_o  out  byte for the transmitter, stable from tx_start to tx_done
//   tx_done_i  in   one-cycle pulse from the transmitter: frame complete
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [UART_DATA_W-1:0] wr_data_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    output logic                   tx_start_o,
    output logic [UART_DATA_W-1:0] tx_data_o,
    input  logic                   tx_done_i
);

    txb_state_e             state_q;
    logic                   tx_start_q;
    logic [UART_DATA_W-1:0] tx_data_q;
    logic [UART_DATA_W-1:0] fifo_rd_data;
    logic                   fifo_empty;
    logic                   fifo_pop;

    // The drain controller is the only consumer of the FIFO.
    assign fifo_pop   = (state_q == TXB_IDLE) & ~fifo_empty;
    assign empty_o    = fifo_empty;
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (wr_en_i),
        .push_data_i (wr_data_i),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rd_data),
        .full_o      (full_o),
        .empty_o     (fifo_empty),
        .count_o     (count_o),
        .overflow_o  (overflow_o)
    );

    // Drain FSM with registered tx_start/tx_data; tx_done outside WAIT is ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= TXB_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= {UART_DATA_W{1'b0}};
        end else begin
            case (state_q)
                TXB_IDLE: begin
                    if (!fifo_empty) begin
                        tx_data_q  <= fifo_rd_data;
                        tx_start_q <= 1'b1;
                        state_q    <= TXB_START;
                    end else begin
                        tx_start_q <= 1'b0;
                    end
                end
                TXB_START: begin
                    tx_start_q <= 1'b0;
                    state_q    <= TXB_WAIT;
                end
                TXB_WAIT: begin
                    tx_start_q <= 1'b0;
                    if (tx_done_i) begin
                        state_q <= TXB_IDLE;
                    end else begin
                        state_q <= TXB_WAIT;
                    end
                end
                default: begin
                    tx_start_q <= 1'b0;
                    state_q    <= TXB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Byte FIFO plus drain controller sitting directly upstream of the UART transmitter. Accepts bursts of bytes from a host-side writer at clock rate and feeds them to the transmitter one frame at a time. Drives the transmitter's start and data inputs, and waits for its done pulse before issuing the next byte. Decouples software/bus write timing from baud-rate serialisation.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- ADDR_W, $clog2(DEPTH), derived localparam (not overridable)

- clock  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low (0 = reset); one clock, async active-low reset is fixed
- wr_en  in  1  write strobe; wr_data pushed on rising edge if full = 0
- wr_data  in  8  byte to enqueue
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write attempted while full (byte dropped)
- tx_start  out  1  one-cycle pulse to transmitter's start input
- tx_data  out  8  byte to transmitter's data input; held stable from tx_start until tx_done
- tx_done  in  1  one-cycle pulse from transmitter: frame complete

## Operation
- Storage: circular buffer, wr_ptr/rd_ptr ADDR_W bits, wrap modulo DEPTH; separate count register (ADDR_W+1 bits), so full/empty are unambiguous.
- Push: wr_en & !full → mem[wr_ptr] = wr_data, wr_ptr++.
- wr_en & full → no write; overflow = 1 next cycle for one cycle. A pop in the same cycle does not rescue the write; full is the pre-edge value.
- Pop: performed only by the drain FSM.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Drain FSM, three states:
  - IDLE: if !empty → pop mem[rd_ptr] into tx_data register, rd_ptr++, go START; else stay.
  - START: tx_start = 1 for this cycle only → WAIT.
  - WAIT: on tx_done → IDLE; else stay. tx_data unchanged throughout.
- tx_done in IDLE or START is ignored.
- No timeout in WAIT; the transmitter is trusted to complete.
- Reset (async assert, any state, including mid-frame):
  - state = IDLE; pointers and count = 0; empty = 1, full = 0.
  - tx_start = 0, tx_data = 8'h00, overflow = 0.
  - Buffered bytes are discarded.
  - A stale tx_done after reset is ignored, since the FSM is in IDLE.

## Timing
- All outputs are registered except full/empty, which are decoded combinationally from the count register.
- Write-to-start latency on an idle, empty buffer:
  - wr_en in cycle 0 → empty = 0 in cycle 1.
  - Pop at end of cycle 1 → tx_start = 1 and tx_data valid in cycle 2.
- Back-to-back frames: tx_done in cycle k → IDLE in k+1 → tx_start in k+2 if !empty. Minimum gap of 2 cycles after done.
- count reflects a push/pop on the cycle after the edge that performed it.
- The full DEPTH entries are usable. With the FSM holding one byte in tx_data, total buffered bytes can reach DEPTH+1.

## Structure
- Shared package uart_pkg:
  - UART_DATA_W = 8
  - typedef enum for drain states {TXB_IDLE, TXB_START, TXB_WAIT}
- The transmitter and receiver reuse UART_DATA_W.
- One sub-module is natural: sync_fifo (parameterised WIDTH/DEPTH; push/pop/full/empty/count/overflow).
- uart_tx_buffer = sync_fifo + drain FSM. sync_fifo is reusable later for an RX-side buffer.

## Test plan
- Reset release, no stimulus:
  - empty = 1, full = 0, count = 0, tx_start never asserts, tx_data = 8'h00.
- Single write 8'hA5 in cycle 0:
  - tx_start pulses in cycle 2 with tx_data = 8'hA5.
  - tx_data stays 8'hA5 until tx_done is returned 20 cycles later.
  - No second tx_start.
- Burst of 3 writes 8'h01, 8'h02, 8'h03 on consecutive cycles:
  - Three tx_start pulses, in order 01, 02, 03.
  - Each pulse comes 2 cycles after the previous tx_done.
  - count peaks at 2.
- With DEPTH = 16 and tx_done withheld, write 18 bytes:
  - First byte popped to tx_data; count reaches 16, full = 1.
  - 18th write gives a single overflow pulse; the 17th byte is accepted.
  - After all tx_done pulses, exactly 17 bytes are emitted, in order.
- Simultaneous wr_en and pop with count = 5: count stays 5, no overflow.
- Wrap-around: 40 bytes streamed with DEPTH = 16 → emitted sequence identical to written sequence.
- Reset asserted mid-WAIT with 4 bytes queued:
  - All outputs take reset values immediately.
  - tx_done pulsed after release produces no tx_start.
  - Next write is transmitted normally.
